// File: rtl/counting_signals.sv
// Registered population count of four request/status lines.
// Count and summary flags load together, one clock after sampling.
module counting_signals (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic [2:0] count,
  output logic       none,
  output logic       all,
  output logic       majority,
  output logic       parity
);

  logic [2:0] next_count;

  // Zero-extended sum of the four lines; max is 4, so no wrap.
  always_comb begin
    next_count = {2'b00, a} + {2'b00, b}
               + {2'b00, c} + {2'b00, d};
  end

  // Output registers; reset clears every flag, including none.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 3'b000;
      none     <= 1'b0;
      all      <= 1'b0;
      majority <= 1'b0;
      parity   <= 1'b0;
    end else begin
      count    <= next_count;
      none     <= (next_count == 3'd0);
      all      <= (next_count == 3'd4);
      majority <= (next_count >= 3'd3);
      parity   <= next_count[0];
    end
  end

endmodule

// File: tb/tb_counting_signals.sv
// Bench for counting_signals: vector table plus scoreboard queue.
// Expected records are queued on drive and popped after the edge.
module tb_counting_signals;

  logic       clk;
  logic       rst;
  logic       a, b, c, d;
  logic [2:0] count;
  logic       none, all, majority, parity;

  typedef struct {
    logic [3:0] in;
    logic [2:0] cnt;
    logic       none;
    logic       all;
    logic       maj;
    logic       par;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[8];

  int passed = 0;
  int total  = 0;

  counting_signals dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .count    (count),
    .none     (none),
    .all      (all),
    .majority (majority),
    .parity   (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t model(
    input logic [3:0] v,
    input logic       r
  );
    vec_t e;
    int   n;
    n     = $countones(v);
    e.in  = v;
    e.cnt = r ? 3'd0 : 3'(n);
    e.none = !r && (n == 0);
    e.all  = !r && (n == 4);
    e.maj  = !r && (n >= 3);
    e.par  = !r && (^v);
    return e;
  endfunction

  function automatic vec_t mk(
    input logic [3:0] v,
    input logic [2:0] cn,
    input logic       nn,
    input logic       al,
    input logic       mj,
    input logic       pr
  );
    vec_t e;
    e.in = v; e.cnt = cn;
    e.none = nn; e.all = al;
    e.maj = mj; e.par = pr;
    return e;
  endfunction

  task automatic chk(
    input string      name,
    input logic [2:0] act,
    input logic [2:0] exp
  );
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0b, expected %0b",
               name, act, exp);
    else
      passed++;
  endtask

  task automatic compare_out(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".count"}, count, e.cnt);
    chk({tag, ".none"}, {2'b0, none}, {2'b0, e.none});
    chk({tag, ".all"}, {2'b0, all}, {2'b0, e.all});
    chk({tag, ".maj"}, {2'b0, majority},
        {2'b0, e.maj});
    chk({tag, ".par"}, {2'b0, parity}, {2'b0, e.par});
  endtask

  task automatic step_exp(
    input string      tag,
    input logic [3:0] v,
    input logic       r,
    input vec_t       e
  );
    {d, c, b, a} = v;
    rst = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic step(
    input string      tag,
    input logic [3:0] v,
    input logic       r
  );
    step_exp(tag, v, r, model(v, r));
  endtask

  initial begin
    tbl[0] = mk(4'b0000, 3'b000, 1, 0, 0, 0);
    tbl[1] = mk(4'b0001, 3'b001, 0, 0, 0, 1);
    tbl[2] = mk(4'b0011, 3'b010, 0, 0, 0, 0);
    tbl[3] = mk(4'b0111, 3'b011, 0, 0, 1, 1);
    tbl[4] = mk(4'b1111, 3'b100, 0, 1, 1, 0);
    tbl[5] = mk(4'b1010, 3'b010, 0, 0, 0, 0);
    tbl[6] = mk(4'b1011, 3'b011, 0, 0, 1, 1);
    tbl[7] = mk(4'b0100, 3'b001, 0, 0, 0, 1);

    rst = 1'b1;
    {d, c, b, a} = 4'b1111;

    // reset held two edges with all inputs high
    @(posedge clk);
    step("reset", 4'b1111, 1'b1);

    // fixed vectors
    for (int i = 0; i < 8; i++)
      step_exp($sformatf("tbl%0d", i),
               tbl[i].in, 1'b0, tbl[i]);

    // exhaustive sweep against popcount model
    for (int i = 0; i < 16; i++)
      step($sformatf("sweep%0d", i), 4'(i), 1'b0);

    // latency: output holds until the next edge
    step("lat0", 4'b0000, 1'b0);
    {d, c, b, a} = 4'b1111;
    #3;
    chk("lat_hold", count, 3'b000);
    step("lat1", 4'b1111, 1'b0);

    // mid-stream reset
    step("mid_pre", 4'b1101, 1'b0);
    chk("mid_pre_cnt", count, 3'b011);
    step("mid_rst", 4'b1101, 1'b1);
    step("mid_post", 4'b1101, 1'b0);
    chk("mid_post_cnt", count, 3'b011);

    // back-to-back toggling
    for (int i = 0; i < 8; i++)
      step($sformatf("tog%0d", i),
           (i % 2 == 0) ? 4'b0000 : 4'b1111, 1'b0);

    if (sb.size() != 0) begin
      total++;
      $display("FAIL sb_drain: got %0d left, expected 0",
               sb.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
